// File: rtl/sdram_sample_stream.sv
// sdram_sample_stream: packs 16-bit samples into 32-bit SDRAM words for record, unpacks them on playback.
// Define SAMPLE_STREAM_STATUS_EN to build the sticky o_overrun / o_underrun flags.
module sdram_sample_stream #(
   parameter int                ADDR_W    = 23,
   parameter logic [ADDR_W-1:0] MAX_WORDS = 23'h7FFFFF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_rec_start,
   input  logic              i_play_start,
   input  logic              i_stop,
   input  logic              i_loop,
   input  logic              i_rec_valid,
   input  logic [15:0]       i_rec_sample,
   input  logic              i_play_req,
   output logic [15:0]       o_play_sample,
   output logic              o_play_valid,
   output logic              o_play_done,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_rec_words,
   output logic              o_overrun,
   output logic              o_underrun,
   output logic [ADDR_W-1:0] o_sdram_addr,
   output logic              o_sdram_read,
   output logic              o_sdram_write,
   output logic [31:0]       o_sdram_writedata,
   input  logic [31:0]       i_sdram_readdata,
   input  logic              i_sdram_finished
);
   typedef enum logic [2:0] {IDLE, REC, REC_FLUSH, PLAY, PLAY_STOP} state_t;
   state_t state, state_nxt;
   logic [ADDR_W-1:0] addr, nxt_addr;
   logic [15:0] pack;
   logic [31:0] rd_buf;
   logic have_half, buf_valid, half;
   logic wr_fin, rd_fin, rec_go, play_go, take, serve, adv, at_end, play_end, flush_wr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = rec_go ? REC : (play_go && o_rec_words != '0) ? PLAY : IDLE;
         REC:       state_nxt = (i_stop || (wr_fin && nxt_addr == MAX_WORDS)) ? REC_FLUSH : REC;
         REC_FLUSH: state_nxt = (!o_sdram_write && !have_half) ? IDLE : REC_FLUSH;
         PLAY:      state_nxt = play_end ? IDLE : i_stop ? PLAY_STOP : PLAY;
         PLAY_STOP: state_nxt = (!o_sdram_read || i_sdram_finished) ? IDLE : PLAY_STOP;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_busy   = state != IDLE;
      wr_fin   = o_sdram_write && i_sdram_finished;
      rd_fin   = o_sdram_read && i_sdram_finished;
      rec_go   = state == IDLE && i_rec_start;
      play_go  = state == IDLE && i_play_start && !i_rec_start;
      take     = state == REC && i_rec_valid;
      serve    = state == PLAY && i_play_req;
      adv      = serve && buf_valid && half;
      nxt_addr = addr + ADDR_W'(1);
      at_end   = nxt_addr == o_rec_words;
      play_end = adv && at_end && !i_loop;
      flush_wr = state == REC_FLUSH && !o_sdram_write && have_half;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr              <= '0;
         o_rec_words       <= '0;
         pack              <= '0;
         have_half         <= 1'b0;
         rd_buf            <= '0;
         buf_valid         <= 1'b0;
         half              <= 1'b0;
         o_play_sample     <= '0;
         o_play_valid      <= 1'b0;
         o_play_done       <= 1'b0;
         o_sdram_addr      <= '0;
         o_sdram_read      <= 1'b0;
         o_sdram_write     <= 1'b0;
         o_sdram_writedata <= '0;
      end else begin
         o_play_valid <= 1'b0;
         o_play_done  <= 1'b0;
         if (wr_fin) begin
            o_sdram_write <= 1'b0;
            addr          <= nxt_addr;
            o_rec_words   <= o_rec_words + ADDR_W'(1);
         end
         if (rd_fin) begin
            o_sdram_read <= 1'b0;
            rd_buf       <= i_sdram_readdata;
            buf_valid    <= 1'b1;
            half         <= 1'b0;
         end
         if (rec_go) begin
            addr        <= '0;
            o_rec_words <= '0;
            have_half   <= 1'b0;
         end
         if (play_go) begin
            addr      <= '0;
            buf_valid <= 1'b0;
            half      <= 1'b0;
            if (o_rec_words == '0) o_play_done <= 1'b1;
            else begin
               o_sdram_addr <= '0;
               o_sdram_read <= 1'b1;
            end
         end
         // a word completing while the previous write is still on the bus is dropped
         if (take) begin
            have_half <= !have_half;
            if (!have_half) pack <= i_rec_sample;
            else if (!o_sdram_write) begin
               o_sdram_write     <= 1'b1;
               o_sdram_writedata <= {i_rec_sample, pack};
               o_sdram_addr      <= addr;
            end
         end
         if (flush_wr) begin
            o_sdram_write     <= 1'b1;
            o_sdram_writedata <= {16'h0000, pack};
            o_sdram_addr      <= addr;
            have_half         <= 1'b0;
         end
         if (serve) begin
            o_play_valid  <= 1'b1;
            o_play_sample <= !buf_valid ? 16'h0000 : half ? rd_buf[31:16] : rd_buf[15:0];
            half          <= buf_valid && !half;
            if (adv) begin
               buf_valid <= 1'b0;
               if (play_end) o_play_done <= 1'b1;
               else begin
                  addr         <= at_end ? '0 : nxt_addr;
                  o_sdram_addr <= at_end ? '0 : nxt_addr;
                  o_sdram_read <= 1'b1;
               end
            end
         end
      end
   end

`ifdef SAMPLE_STREAM_STATUS_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_overrun  <= 1'b0;
         o_underrun <= 1'b0;
      end else if (state == IDLE && (i_rec_start || i_play_start)) begin
         o_overrun  <= 1'b0;
         o_underrun <= 1'b0;
      end else begin
         if (take && have_half && o_sdram_write) o_overrun <= 1'b1;
         if (serve && !buf_valid) o_underrun <= 1'b1;
      end
   end
`else
   assign o_overrun  = 1'b0;
   assign o_underrun = 1'b0;
`endif
endmodule

// File: tb/tb_sdram_sample_stream.sv
// tb_sdram_sample_stream: directed record/playback vectors against a small latency-controlled SDRAM bus model.
module tb_sdram_sample_stream;
   localparam int AW = 23;
`ifdef SAMPLE_STREAM_STATUS_EN
   localparam logic ST = 1'b1;
`else
   localparam logic ST = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic rec_start = 0, play_start = 0, stop = 0, loop_i = 0, rec_valid = 0, play_req = 0;
   logic [15:0] smp = '0;
   logic [15:0] psample;
   logic pval, pdone, busy, ovr, und, srd, swr, fin;
   logic [AW-1:0] rec_words, saddr;
   logic [31:0] swdata, rdata;

   int n_cmp = 0, n_err = 0, both_err = 0, lat = 3, cnt = 0;
   bit hold = 0;
   logic [31:0] mem [16];
   logic [AW-1:0] log_addr [$];
   logic [31:0] log_data [$];
   bit log_wr [$];

   always #5 clk = ~clk;

   sdram_sample_stream dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rec_start(rec_start), .i_play_start(play_start),
      .i_stop(stop), .i_loop(loop_i), .i_rec_valid(rec_valid), .i_rec_sample(smp),
      .i_play_req(play_req), .o_play_sample(psample), .o_play_valid(pval), .o_play_done(pdone),
      .o_busy(busy), .o_rec_words(rec_words), .o_overrun(ovr), .o_underrun(und),
      .o_sdram_addr(saddr), .o_sdram_read(srd), .o_sdram_write(swr), .o_sdram_writedata(swdata),
      .i_sdram_readdata(rdata), .i_sdram_finished(fin)
   );

   assign rdata = mem[saddr[3:0]];

   // finished rises after the request has been seen high for lat edges; hold freezes the bus
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fin <= 1'b0;
         cnt <= 0;
      end else begin
         if (srd && swr) both_err <= both_err + 1;
         if (fin) begin
            fin <= 1'b0;
            cnt <= 0;
            if (srd || swr) begin
               log_addr.push_back(saddr);
               log_data.push_back(swr ? swdata : rdata);
               log_wr.push_back(swr);
               if (swr) mem[saddr[3:0]] <= swdata;
            end
         end else if (!hold && (srd || swr)) begin
            cnt <= cnt + 1;
            fin <= (cnt + 1 == lat);
         end
      end
   end

   typedef struct {bit start; bit loop; logic [15:0] exp; bit done;} play_t;
   play_t pv [10];

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy && n < max) begin
         tick;
         n++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   task automatic rec_sample(input logic [15:0] s, input int gap);
      rec_valid = 1;
      smp = s;
      tick;
      rec_valid = 0;
      repeat (gap) tick;
   endtask

   task automatic pulse_rec;
      rec_start = 1;
      tick;
      rec_start = 0;
   endtask

   task automatic pulse_play;
      play_start = 1;
      tick;
      play_start = 0;
   endtask

   task automatic pulse_stop;
      stop = 1;
      tick;
      stop = 0;
   endtask

   task automatic clear_log;
      log_addr.delete();
      log_data.delete();
      log_wr.delete();
   endtask

   initial begin
      bit saw;
      int n;
      pv = '{'{1, 0, 16'h0001, 0}, '{0, 0, 16'h0002, 0}, '{0, 0, 16'h0003, 0}, '{0, 0, 16'h0004, 1},
             '{1, 1, 16'h0001, 0}, '{0, 1, 16'h0002, 0}, '{0, 1, 16'h0003, 0}, '{0, 1, 16'h0004, 0},
             '{0, 1, 16'h0001, 0}, '{0, 1, 16'h0002, 0}};
      foreach (mem[i]) mem[i] = '0;
      #1 rst_n = 0;
      repeat (2) tick;
      chk("rst_busy", busy, 0);
      chk("rst_write", swr, 0);
      chk("rst_read", srd, 0);
      chk("rst_pvalid", pval, 0);
      chk("rst_pdone", pdone, 0);
      chk("rst_rec_words", rec_words, 0);
      chk("rst_addr", saddr, 0);
      chk("rst_wdata", swdata, 0);
      chk("rst_flags", {ovr, und}, 0);
      rst_n = 1;
      tick;

      // record 1..4, writes paced by a 3-cycle bus
      clear_log();
      pulse_rec();
      chk("rec_busy", busy, 1);
      rec_sample(16'h0001, 7);
      rec_valid = 1;
      smp = 16'h0002;
      tick;
      rec_valid = 0;
      chk("rec_wr_req", swr, 1);
      chk("rec_wr_data", swdata, 32'h0002_0001);
      chk("rec_wr_addr", saddr, 0);
      repeat (7) tick;
      rec_sample(16'h0003, 7);
      rec_sample(16'h0004, 7);
      pulse_stop();
      wait_idle(20);
      chk("rec_nwr", log_addr.size(), 2);
      chk("rec_a0", log_addr[0], 0);
      chk("rec_d0", log_data[0], 32'h0002_0001);
      chk("rec_a1", log_addr[1], 1);
      chk("rec_d1", log_data[1], 32'h0004_0003);
      chk("rec_words", rec_words, 2);
      chk("rec_ovr", ovr, 0);

      // playback table: one pass without loop, then a looping pass
      clear_log();
      for (int i = 0; i < 10; i++) begin
         if (pv[i].start) begin
            loop_i = pv[i].loop;
            pulse_play();
            repeat (10) tick;
         end
         play_req = 1;
         tick;
         play_req = 0;
         chk($sformatf("play%0d_valid", i), pval, 1);
         chk($sformatf("play%0d_sample", i), psample, pv[i].exp);
         chk($sformatf("play%0d_done", i), pdone, pv[i].done);
         tick;
         chk($sformatf("play%0d_valid_off", i), pval, 0);
         repeat (18) tick;
      end
      pulse_stop();
      wait_idle(20);
      loop_i = 0;
      chk("play_nrd", log_addr.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("play_rd%0d_addr", i), log_addr[i], i % 2);
         chk($sformatf("play_rd%0d_kind", i), log_wr[i], 0);
      end

      // odd sample count: the held half is flushed with a zero upper half
      clear_log();
      pulse_rec();
      rec_sample(16'hAAAA, 7);
      rec_sample(16'hBBBB, 7);
      rec_sample(16'hCCCC, 7);
      pulse_stop();
      wait_idle(20);
      chk("flush_nwr", log_addr.size(), 2);
      chk("flush_d0", log_data[0], 32'hBBBB_AAAA);
      chk("flush_a1", log_addr[1], 1);
      chk("flush_d1", log_data[1], 32'h0000_CCCC);
      chk("flush_words", rec_words, 2);

      // overrun: bus stalls while a second word completes
      clear_log();
      hold = 1;
      pulse_rec();
      rec_sample(16'h0001, 0);
      rec_sample(16'h0002, 0);
      rec_sample(16'h0003, 0);
      rec_sample(16'h0004, 0);
      chk("ovr_wr_held", swr, 1);
      chk("ovr_wr_data", swdata, 32'h0002_0001);
      chk("ovr_wr_addr", saddr, 0);
      chk("ovr_flag", ovr, ST);
      repeat (36) tick;
      chk("ovr_wr_still", swr, 1);
      hold = 0;
      repeat (6) tick;
      chk("ovr_wr_done", swr, 0);
      pulse_stop();
      wait_idle(20);
      chk("ovr_words", rec_words, 1);
      chk("ovr_nwr", log_addr.size(), 1);
      chk("ovr_sticky", ovr, ST);

      // underrun on an immediate request, then stop while the read is held
      clear_log();
      hold = 1;
      pulse_play();
      chk("und_rd_req", srd, 1);
      chk("und_ovr_clr", ovr, 0);
      play_req = 1;
      tick;
      play_req = 0;
      chk("und_valid", pval, 1);
      chk("und_sample", psample, 0);
      chk("und_flag", und, ST);
      pulse_stop();
      repeat (5) tick;
      chk("stop_rd_held", srd, 1);
      chk("stop_busy", busy, 1);
      hold = 0;
      saw = 0;
      n = 0;
      while (busy && n < 20) begin
         tick;
         saw |= pval;
         n++;
      end
      chk("stop_idle", busy, 0);
      chk("stop_no_valid", saw, 0);
      chk("stop_rd_off", srd, 0);
      chk("stop_nrd", log_addr.size(), 1);
      chk("und_sticky", und, ST);

      // asynchronous reset while a write is stalled
      hold = 1;
      pulse_rec();
      rec_sample(16'h0005, 0);
      rec_sample(16'h0006, 0);
      chk("rstw_wr_req", swr, 1);
      #2 rst_n = 0;
      #1;
      chk("rstw_wr_drop", swr, 0);
      chk("rstw_busy", busy, 0);
      chk("rstw_words", rec_words, 0);
      tick;
      rst_n = 1;
      hold = 0;
      tick;

      // empty recording: playback ends at once
      pulse_play();
      chk("empty_done", pdone, 1);
      chk("empty_busy", busy, 0);
      chk("empty_rd", srd, 0);
      tick;
      chk("empty_done_off", pdone, 0);

      // simultaneous starts: record wins, play requests ignored outside PLAY
      rec_start = 1;
      play_start = 1;
      tick;
      rec_start = 0;
      play_start = 0;
      chk("both_busy", busy, 1);
      tick;
      chk("both_no_rd", srd, 0);
      play_req = 1;
      tick;
      play_req = 0;
      chk("req_in_rec", pval, 0);
      pulse_stop();
      wait_idle(20);
      chk("rd_wr_overlap", both_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
